booth_seq_multiplier: RTL and testbench



---
 rtl/booth_seq_multiplier_if.sv | 32 +++
 rtl/booth_seq_multiplier.sv | 154 +++++++++++++++
 tb/tb_booth_seq_multiplier.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/booth_seq_multiplier_if.sv
// Operand/result bus of the sequential radix-4 Booth multiplier.
//
// Handshake rules: a transfer happens on a rising clock edge where both
// valid and ready of that channel are high. The producer keeps its payload
// stable while valid is high and ready is low. On the operand channel the
// producer drives valid_i/a_i/b_i and the multiplier drives ready_o. On the
// result channel the multiplier drives valid_o/product_o and the consumer
// drives ready_i. busy_o is a status flag with no handshake.
interface booth_seq_multiplier_if #(
    parameter int WIDTH = 24
);
    logic                 valid_i;
    logic                 ready_o;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [2*WIDTH-1:0]   product_o;
    logic                 busy_o;

    // Multiplier side
    modport slave (
        input  valid_i, a_i, b_i, ready_i,
        output ready_o, valid_o, product_o, busy_o
    );

    // Producer/consumer side
    modport master (
        output valid_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, product_o, busy_o
    );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: one Booth digit of the multiplier is
// retired per clock, the selected partial product (0, +-A, +-2A) is added to
// a signed accumulator wide enough that the exact unsigned product a*b never
// overflows. IDLE accepts operands, BUSY runs N = (WIDTH+2)/2 digits, DONE
// presents the product until the consumer takes it.
module booth_seq_multiplier #(
    parameter int WIDTH = 24
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    booth_seq_multiplier_if.slave    bus,
    output logic [1:0]               state_dbg_o
);

    // Number of Booth digits; b is extended with two zero bits on top so the
    // last digit always sees a non-negative multiplier.
    localparam int N     = (WIDTH + 2) / 2;
    // Accumulator: 2*WIDTH product bits plus headroom for +-2A shifted by
    // the top digit weight and a sign bit.
    localparam int ACC_W = 2 * WIDTH + 3;
    // Multiplier shift register: {2'b00, b, implicit bit -1}.
    localparam int BW    = WIDTH + 3;
    localparam int CW    = $clog2(N + 1);

    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   a_sh_q, a_sh_d;
    logic [BW-1:0]      b_sh_q, b_sh_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               accept;
    logic               last_digit;
    logic [2:0]         digit;
    logic               pp_zero;
    logic               pp_negate;
    logic               pp_shift;
    logic [ACC_W-1:0]   pp_mag;
    logic [ACC_W-1:0]   pp;
    logic [ACC_W-1:0]   acc_sum;

    assign accept     = (state_q == S_IDLE) && bus.valid_i;
    assign last_digit = (count_q == LAST_DIGIT);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.valid_i) state_d = S_BUSY;
            S_BUSY:  if (last_digit)  state_d = S_DONE;
            S_DONE:  if (bus.ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded purely from state and registered product
    always_comb begin
        bus.ready_o   = (state_q == S_IDLE);
        bus.busy_o    = (state_q == S_BUSY);
        bus.valid_o   = (state_q == S_DONE);
        bus.product_o = product_q;
        state_dbg_o   = state_q;
    end

    // Booth digit decode and partial product selection for the current digit
    always_comb begin
        digit     = b_sh_q[2:0];
        pp_zero   = 1'b0;
        pp_negate = 1'b0;
        pp_shift  = 1'b0;
        case (digit)
            3'b000:  pp_zero = 1'b1;
            3'b001:  pp_zero = 1'b0;
            3'b010:  pp_zero = 1'b0;
            3'b011:  pp_shift = 1'b1;
            3'b100:  begin pp_negate = 1'b1; pp_shift = 1'b1; end
            3'b101:  pp_negate = 1'b1;
            3'b110:  pp_negate = 1'b1;
            3'b111:  pp_zero = 1'b1;
            default: pp_zero = 1'b1;
        endcase

        // a_sh_q already carries the 4^i weight of the current digit
        pp_mag = pp_shift ? (a_sh_q << 1) : a_sh_q;
        if (pp_zero) begin
            pp = '0;
        end else if (pp_negate) begin
            pp = -pp_mag;
        end else begin
            pp = pp_mag;
        end
        acc_sum = acc_q + pp;
    end

    // Datapath next values: load on accept, step one digit per BUSY cycle
    always_comb begin
        acc_d     = acc_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        count_d   = count_q;
        product_d = product_q;
        if (accept) begin
            acc_d   = '0;
            a_sh_d  = {{(ACC_W - WIDTH){1'b0}}, bus.a_i};
            b_sh_d  = {2'b00, bus.b_i, 1'b0};
            count_d = '0;
        end else if (state_q == S_BUSY) begin
            acc_d   = acc_sum;
            a_sh_d  = a_sh_q << 2;
            b_sh_d  = b_sh_q >> 2;
            count_d = count_q + CW'(1);
            if (last_digit) begin
                // Upper accumulator bits are zero for an unsigned product
                product_d = acc_sum[2*WIDTH-1:0];
            end
        end
    end

    // Datapath registers; product survives the output handshake until the
    // next completion or reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q     <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            acc_q     <= acc_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier (WIDTH=24): a table of operand
// pairs with hand-computed products, plus sequences for backpressure and
// reset in the middle of an operation.
module tb_booth_seq_multiplier;

    localparam int WIDTH = 24;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] exp;
    } vec_t;

    logic       clk;
    logic       reset_i;
    logic [1:0] state_dbg;

    int total;
    int bad;

    booth_seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

    booth_seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for valid_o, counting edges from the current position; bounded
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!bus.valid_o && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // Present one operand pair and check latency, busy window, product and
    // the single-cycle valid pulse (ready_i held high)
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2*WIDTH-1:0] exp, input string name);
        int edges;
        int busy_cnt;
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        edges = 0;
        while (!bus.ready_o && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        @(posedge clk); #1;                 // accept edge
        bus.valid_i = 1'b0;
        bus.a_i     = WIDTH'($urandom);
        bus.b_i     = WIDTH'($urandom);
        busy_cnt = bus.busy_o ? 1 : 0;
        edges = 0;
        while (!bus.valid_o && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (bus.busy_o && !bus.valid_o) busy_cnt++;
        end
        chk({name, "_latency"}, 64'(edges), 64'd13);
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'd13);
        chk({name, "_product"}, 64'(bus.product_o), 64'(exp));
        chk({name, "_done_busy"}, 64'(bus.busy_o), 64'd0);
        @(posedge clk); #1;
        chk({name, "_valid_drop"}, 64'(bus.valid_o), 64'd0);
        chk({name, "_ready_back"}, 64'(bus.ready_o), 64'd1);
    endtask

    initial begin
        vec_t vecs[10];
        int   edges;
        bit   seen;

        vecs[0] = '{a: 24'h000003, b: 24'h000005, exp: 48'h00000000000F};
        vecs[1] = '{a: 24'hFFFFFF, b: 24'hFFFFFF, exp: 48'hFFFFFE000001};
        vecs[2] = '{a: 24'h000003, b: 24'hAAAAAA, exp: 48'h000001FFFFFE};
        vecs[3] = '{a: 24'hABCDEF, b: 24'h000000, exp: 48'h000000000000};
        vecs[4] = '{a: 24'h000001, b: 24'h000001, exp: 48'h000000000001};
        vecs[5] = '{a: 24'hFFFFFF, b: 24'h000001, exp: 48'h000000FFFFFF};
        vecs[6] = '{a: 24'h800000, b: 24'h000002, exp: 48'h000001000000};
        vecs[7] = '{a: 24'hFFFFFF, b: 24'h800000, exp: 48'h7FFFFF800000};
        vecs[8] = '{a: 24'h555555, b: 24'h000003, exp: 48'h000000FFFFFF};
        vecs[9] = '{a: 24'h000000, b: 24'hFFFFFF, exp: 48'h000000000000};

        total = 0;
        bad   = 0;

        // Reset with random inputs on the bus
        reset_i = 1'b1;
        repeat (2) begin
            bus.valid_i = 1'($urandom);
            bus.ready_i = 1'($urandom);
            bus.a_i     = WIDTH'($urandom);
            bus.b_i     = WIDTH'($urandom);
            @(posedge clk); #1;
        end
        reset_i     = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        chk("reset_ready", 64'(bus.ready_o), 64'd1);
        chk("reset_valid", 64'(bus.valid_o), 64'd0);
        chk("reset_busy", 64'(bus.busy_o), 64'd0);
        chk("reset_product", 64'(bus.product_o), 64'd0);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 5 cycles while a new pair is waiting
        bus.ready_i = 1'b0;
        bus.valid_i = 1'b1;
        bus.a_i     = 24'h123456;
        bus.b_i     = 24'h000010;
        @(posedge clk); #1;                 // accepted (block was idle)
        bus.valid_i = 1'b0;
        wait_valid(edges);
        chk("bp_latency", 64'(edges), 64'd13);
        bus.valid_i = 1'b1;
        bus.a_i     = 24'h000005;
        bus.b_i     = 24'h000006;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold_valid%0d", k), 64'(bus.valid_o), 64'd1);
            chk($sformatf("bp_hold_product%0d", k), 64'(bus.product_o), 64'h1234560);
            chk($sformatf("bp_hold_ready%0d", k), 64'(bus.ready_o), 64'd0);
        end
        bus.ready_i = 1'b1;
        @(posedge clk); #1;                 // output handshake edge
        chk("bp_idle_valid", 64'(bus.valid_o), 64'd0);
        chk("bp_idle_ready", 64'(bus.ready_o), 64'd1);
        chk("bp_product_retained", 64'(bus.product_o), 64'h1234560);
        @(posedge clk); #1;                 // pending pair accepted
        chk("bp_next_busy", 64'(bus.busy_o), 64'd1);
        chk("bp_next_ready", 64'(bus.ready_o), 64'd0);
        bus.valid_i = 1'b0;
        wait_valid(edges);
        chk("bp_next_latency", 64'(edges), 64'd13);
        chk("bp_next_product", 64'(bus.product_o), 64'h1E);
        @(posedge clk); #1;
        chk("bp_next_valid_drop", 64'(bus.valid_o), 64'd0);

        // Reset during the 6th BUSY cycle of 7*9
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.a_i     = 24'h000007;
        bus.b_i     = 24'h000009;
        @(posedge clk); #1;                 // accept; now in BUSY cycle 1
        bus.valid_i = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_busy_before", 64'(bus.busy_o), 64'd1);
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        chk("rst_mid_ready", 64'(bus.ready_o), 64'd1);
        chk("rst_mid_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_mid_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_mid_product", 64'(bus.product_o), 64'd0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.valid_o || bus.busy_o) seen = 1'b1;
        end
        chk("rst_mid_no_result", 64'(seen), 64'd0);
        run_op(24'h000007, 24'h000009, 48'h00000000003F, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
